// File: rtl/matvec_pkg.sv
// Shared types and width math for the matvec datapaths.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } mv_state_e;

    // Accumulator width for n signed products of a w_e-bit and a w_k-bit operand
    function automatic int w_acc(input int w_e, input int w_k, input int n);
        return w_e + w_k + $clog2(n);
    endfunction

endpackage

// File: rtl/matvec_mac_row.sv
// C parallel signed multiply-accumulate lanes sharing one scalar operand.
module matvec_mac_row
    import matvec_pkg::*;
#(
    parameter int C   = 8,
    parameter int W_E = 19,
    parameter int W_K = 8,
    parameter int W_O = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [C-1:0][W_K-1:0]     w,
    input  logic [W_E-1:0]            x,
    output logic [C-1:0][W_O-1:0]     acc
);

    for (genvar c = 0; c < C; c++) begin : g_lane
        logic signed [W_E+W_K-1:0] prod;

        // Full-precision signed product of this lane's weight and the scalar
        always_comb begin
            prod = $signed(w[c]) * $signed(x);
        end

        // Lane accumulator: clear on result hand-off, add sign-extended product on a beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc[c] <= '0;
            end else if (clr) begin
                acc[c] <= '0;
            end else if (en) begin
                acc[c] <= acc[c] + W_O'(prod);
            end
        end
    end

endmodule

// File: rtl/matvec_tmul_stream.sv
// Transposed matrix-vector multiply x_o = K^T * y over a ready/valid element stream.
module matvec_tmul_stream
    import matvec_pkg::*;
#(
    parameter  int R   = 8,
    parameter  int C   = 8,
    parameter  int W_E = 19,
    parameter  int W_K = 8,
    localparam int W_O = w_acc(W_E, W_K, R)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cen,
    input  logic [R-1:0][C-1:0][W_K-1:0]   k,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W_E-1:0]                 s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [C-1:0][W_O-1:0]          m_data,
    output logic                           len_err
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

    mv_state_e     state;
    mv_state_e     state_nxt;
    logic [RW-1:0] row;
    logic          row_last;
    logic          s_fire;
    logic          m_fire;

    // Handshake qualifiers; cen low means no transfer is counted
    always_comb begin
        row_last = (row == ROW_LAST);
        s_fire   = s_valid & s_ready & cen;
        m_fire   = m_valid & m_ready & cen;
    end

    // State register, frozen while cen is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE once, close frame on the R-th beat, reopen on result accept
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ACC;
            ACC:     if (s_fire && row_last) state_nxt = OUT;
            OUT:     if (m_fire) state_nxt = ACC;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        s_ready = (state == ACC);
        m_valid = (state == OUT);
    end

    // Row counter advances per accepted beat and wraps at the frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if (s_fire) begin
            row <= row_last ? '0 : row + 1'b1;
        end
    end

    // Sticky framing error when s_last disagrees with the row counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err <= 1'b0;
        end else if (s_fire && (s_last != row_last)) begin
            len_err <= 1'b1;
        end
    end

    // Accumulators double as the registered result; they only move in ACC so stay stable in OUT
    matvec_mac_row #(
        .C   (C),
        .W_E (W_E),
        .W_K (W_K),
        .W_O (W_O)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (m_fire),
        .en  (s_fire),
        .w   (k[row]),
        .x   (s_data),
        .acc (m_data)
    );

endmodule

// File: tb/tb_matvec_tmul_stream.sv
// Randomized self-checking bench for matvec_tmul_stream against a K^T*y reference.
module tb_matvec_tmul_stream;
    import matvec_pkg::*;

    localparam int R   = 8;
    localparam int C   = 8;
    localparam int W_E = 19;
    localparam int W_K = 8;
    localparam int W_O = w_acc(W_E, W_K, R);

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          cen;
    logic [R-1:0][C-1:0][W_K-1:0]  k;
    logic                          s_valid;
    logic                          s_ready;
    logic [W_E-1:0]                s_data;
    logic                          s_last;
    logic                          m_valid;
    logic                          m_ready;
    logic [C-1:0][W_O-1:0]         m_data;
    logic                          len_err;

    int kmat [R][C];
    int yv   [R];
    longint expv [C];
    int n_vec  = 0;
    int n_fail = 0;

    matvec_tmul_stream #(
        .R   (R),
        .C   (C),
        .W_E (W_E),
        .W_K (W_K)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .k       (k),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int c);
        return longint'($signed(m_data[c]));
    endfunction

    // Reference: x_o[c] = sum_r k[r][c] * y[r]; also drives the packed k bus
    task automatic load_frame();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                k[r][c] = W_K'(kmat[r][c]);
        for (int c = 0; c < C; c++) begin
            expv[c] = 0;
            for (int r = 0; r < R; r++)
                expv[c] += longint'(kmat[r][c]) * longint'(yv[r]);
        end
    endtask

    task automatic rand_frame();
        for (int r = 0; r < R; r++) begin
            yv[r] = int'($urandom_range(0, (1 << W_E) - 1)) - (1 << (W_E - 1));
            for (int c = 0; c < C; c++)
                kmat[r][c] = int'($urandom_range(0, 255)) - 128;
        end
        load_frame();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends nbeats elements; called and returns at a negedge
    task automatic send_frame(input int nbeats, input int gap_pct,
                              input int bad_beat, input int stall_beat);
        int beat = 0;
        int cyc  = 0;
        bit stalled = 0;
        bit fire;
        while (beat < nbeats && cyc < 400) begin
            if (beat == stall_beat && !stalled) begin
                stalled = 1;
                s_valid = 1'b1;
                s_data  = W_E'(yv[beat]);
                s_last  = (beat == R - 1);
                cen     = 1'b0;
                repeat (3) begin
                    tick();
                    check("stall_s_ready", longint'(s_ready), 1);
                    check("stall_m_valid", longint'(m_valid), 0);
                end
                cen = 1'b1;
            end
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = W_E'(yv[beat]);
            s_last  = (beat == R - 1) ^ (beat == bad_beat);
            fire    = s_valid && s_ready && cen;
            tick();
            if (fire) beat++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (beat < nbeats) check("send_timeout", beat, nbeats);
    endtask

    // Expects the result immediately after the last beat, holds it, then accepts it
    task automatic recv_frame(input int hold, input int cen_hold);
        int bad = 0;
        check("latency_m_valid", longint'(m_valid), 1);
        check("out_s_ready", longint'(s_ready), 0);
        for (int c = 0; c < C; c++)
            check($sformatf("m_data[%0d]", c), lane(c), expv[c]);
        m_ready = 1'b0;
        repeat (hold) begin
            tick();
            if (!m_valid || s_ready) bad++;
            for (int c = 0; c < C; c++)
                if (lane(c) != expv[c]) bad++;
        end
        if (hold > 0) check("hold_stable", bad, 0);
        if (cen_hold > 0) begin
            bad = 0;
            m_ready = 1'b1;
            cen     = 1'b0;
            repeat (cen_hold) begin
                tick();
                if (!m_valid || s_ready) bad++;
                for (int c = 0; c < C; c++)
                    if (lane(c) != expv[c]) bad++;
            end
            cen = 1'b1;
            check("cen_out_frozen", bad, 0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("post_m_valid", longint'(m_valid), 0);
        check("post_s_ready", longint'(s_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        int bad = 0;
        for (int c = 0; c < C; c++)
            if (lane(c) != 0) bad++;
        check({tag, "_s_ready"}, longint'(s_ready), 0);
        check({tag, "_m_valid"}, longint'(m_valid), 0);
        check({tag, "_len_err"}, longint'(len_err), 0);
        check({tag, "_m_data"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; k = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_to_acc", longint'(s_ready), 1);

        // Identity weights, y = 1..8, continuous valid
        for (int r = 0; r < R; r++) begin
            yv[r] = r + 1;
            for (int c = 0; c < C; c++) kmat[r][c] = (r == c) ? 1 : 0;
        end
        load_frame();
        send_frame(R, 0, -1, -1);
        recv_frame(0, 0);
        check("ident_len_err", longint'(len_err), 0);

        // Full-scale negative weights, full-scale positive elements
        for (int r = 0; r < R; r++) begin
            yv[r] = (1 << (W_E - 1)) - 1;
            for (int c = 0; c < C; c++) kmat[r][c] = -128;
        end
        load_frame();
        send_frame(R, 0, -1, -1);
        recv_frame(0, 0);

        // Random data, gaps on the input, output held off for 5 cycles
        repeat (4) begin
            rand_frame();
            send_frame(R, 40, -1, -1);
            recv_frame(5, 0);
        end

        // s_last asserted early on the third beat
        rand_frame();
        send_frame(R, 20, 2, -1);
        recv_frame(0, 0);
        check("len_err_set", longint'(len_err), 1);
        rand_frame();
        send_frame(R, 0, -1, -1);
        recv_frame(0, 0);
        check("len_err_sticky", longint'(len_err), 1);

        // cen low mid-frame and during OUT
        rand_frame();
        send_frame(R, 0, -1, 4);
        recv_frame(2, 3);

        // Reset after four beats discards the partial frame
        rand_frame();
        send_frame(4, 0, -1, -1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        rand_frame();
        send_frame(R, 30, -1, -1);
        recv_frame(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
